// File: rtl/scpad_pkg.sv
// scpad_pkg: shared types and defaults for the scratchpad DRAM request queue
//   DRAM_Q_*      default sizing of the queue and its fields
//   dram_q_entry_t queue entry layout at default field widths
package scpad_pkg;
    localparam int DRAM_Q_DEPTH    = 8;
    localparam int DRAM_Q_ADDR_W   = 32;
    localparam int DRAM_Q_DATA_W   = 128;
    localparam int DRAM_Q_ID_W     = 8;
    localparam int DRAM_Q_NBYTES_W = 5;
    localparam int DRAM_Q_SUB_W    = 3;

    typedef struct packed {
        logic                       valid;
        logic                       write;
        logic                       has_data;
        logic [DRAM_Q_ID_W-1:0]     id;
        logic [DRAM_Q_SUB_W-1:0]    sub_id;
        logic [DRAM_Q_SUB_W-1:0]    num_req;
        logic [DRAM_Q_ADDR_W-1:0]   addr;
        logic [DRAM_Q_NBYTES_W-1:0] num_bytes;
        logic [DRAM_Q_DATA_W-1:0]   wdata;
    } dram_q_entry_t;
endpackage

// File: rtl/dram_req_wdata_sel.sv
// dram_req_wdata_sel: finds the oldest write still waiting for data
//   rptr_i  queue head index (oldest entry)
//   cand_i  per-entry flag: valid write without data
//   idx_o   index of the oldest flagged entry, searched from rptr_i
//   found_o any entry flagged
module dram_req_wdata_sel #(
    parameter int DEPTH = 8
) (
    input  logic [$clog2(DEPTH)-1:0] rptr_i,
    input  logic [DEPTH-1:0]         cand_i,
    output logic [$clog2(DEPTH)-1:0] idx_o,
    output logic                     found_o
);
    localparam int PW = $clog2(DEPTH);
    // Scan from youngest to oldest so the entry closest to rptr_i wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand_i[rptr_i + PW'(i)]) begin
                found_o = 1'b1;
                idx_o   = rptr_i + PW'(i);
            end
        end
    end
endmodule

// File: rtl/dram_req_queue_param.sv
// dram_req_queue_param: in-order DRAM request queue between scratchpad scheduler and DRAM
//   enq_*            sub-request from the scheduler (enq_ready = !full)
//   wdata_valid/wdata SRAM data for the oldest write awaiting data
//   dram_req_*       head entry, valid once complete; dram_stall backpressure
//   burst_complete / transaction_complete / done_id  registered acceptance pulses
//   full / empty / count / wdata_err  status (wdata_err sticky until reset)
//   Macro DRAM_REQ_QUEUE_STATS_EN adds saturating stat_rd_cnt/stat_wr_cnt/stat_stall_cnt.
module dram_req_queue_param
    import scpad_pkg::*;
#(
    parameter int DEPTH    = DRAM_Q_DEPTH,
    parameter int ADDR_W   = DRAM_Q_ADDR_W,
    parameter int DATA_W   = DRAM_Q_DATA_W,
    parameter int ID_W     = DRAM_Q_ID_W,
    parameter int NBYTES_W = DRAM_Q_NBYTES_W,
    parameter int SUB_W    = DRAM_Q_SUB_W
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic                       enq_write,
    input  logic [ID_W-1:0]            enq_id,
    input  logic [SUB_W-1:0]           enq_sub_id,
    input  logic [SUB_W-1:0]           enq_num_req,
    input  logic [ADDR_W-1:0]          enq_addr,
    input  logic [NBYTES_W-1:0]        enq_num_bytes,
    input  logic                       wdata_valid,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       dram_stall,
    output logic                       dram_req_valid,
    output logic                       dram_req_write,
    output logic [ID_W-1:0]            dram_req_id,
    output logic [ADDR_W-1:0]          dram_req_addr,
    output logic [NBYTES_W-1:0]        dram_req_num_bytes,
    output logic [DATA_W-1:0]          dram_req_wdata,
    output logic                       burst_complete,
    output logic                       transaction_complete,
    output logic [ID_W-1:0]            done_id,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       wdata_err
`ifdef DRAM_REQ_QUEUE_STATS_EN
    ,
    output logic [31:0]                stat_rd_cnt,
    output logic [31:0]                stat_wr_cnt,
    output logic [31:0]                stat_stall_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                valid;
        logic                write;
        logic                has_data;
        logic [ID_W-1:0]     id;
        logic [SUB_W-1:0]    sub_id;
        logic [SUB_W-1:0]    num_req;
        logic [ADDR_W-1:0]   addr;
        logic [NBYTES_W-1:0] num_bytes;
        logic [DATA_W-1:0]   wdata;
    } entry_t;

    entry_t           q_q [DEPTH];
    entry_t           q_d [DEPTH];
    entry_t           head;
    logic [PW-1:0]    rptr_q, wptr_q, sel_idx;
    logic [CW-1:0]    count_q;
    logic [ID_W-1:0]  done_id_q;
    logic [DEPTH-1:0] cand;
    logic             err_q, burst_q, trans_q, sel_found;
    logic             enq, acc, fill_old, fill_new, drop;

    assign head      = q_q[rptr_q];
    assign full      = count_q == CW'(DEPTH);
    assign empty     = count_q == '0;
    assign enq_ready = !full;
    assign count     = count_q;
    assign wdata_err = err_q;

    assign dram_req_valid     = head.valid && head.has_data;
    assign dram_req_write     = head.write;
    assign dram_req_id        = head.id;
    assign dram_req_addr      = head.addr;
    assign dram_req_num_bytes = head.num_bytes;
    assign dram_req_wdata     = head.wdata;

    assign burst_complete       = burst_q;
    assign transaction_complete = trans_q;
    assign done_id              = done_id_q;

    assign enq = enq_valid && enq_ready;
    assign acc = dram_req_valid && !dram_stall;

    always_comb begin
        cand = '0;
        for (int i = 0; i < DEPTH; i++)
            cand[i] = q_q[i].valid && q_q[i].write && !q_q[i].has_data;
    end

    dram_req_wdata_sel #(.DEPTH(DEPTH)) u_sel (
        .rptr_i (rptr_q),
        .cand_i (cand),
        .idx_o  (sel_idx),
        .found_o(sel_found)
    );

    // A write entering this cycle takes the beat only if nothing older is waiting.
    assign fill_old = wdata_valid && sel_found;
    assign fill_new = wdata_valid && !sel_found && enq && enq_write;
    assign drop     = wdata_valid && !sel_found && !fill_new;

    always_comb begin
        q_d = q_q;
        if (acc)
            q_d[rptr_q].valid = 1'b0;
        if (fill_old) begin
            q_d[sel_idx].has_data = 1'b1;
            q_d[sel_idx].wdata    = wdata;
        end
        if (enq)
            q_d[wptr_q] = '{valid: 1'b1, write: enq_write, has_data: !enq_write || fill_new,
                            id: enq_id, sub_id: enq_sub_id, num_req: enq_num_req,
                            addr: enq_addr, num_bytes: enq_num_bytes,
                            wdata: fill_new ? wdata : '0};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++)
                q_q[i] <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            burst_q   <= 1'b0;
            trans_q   <= 1'b0;
            done_id_q <= '0;
        end else begin
            q_q       <= q_d;
            rptr_q    <= rptr_q + PW'(acc);
            wptr_q    <= wptr_q + PW'(enq);
            count_q   <= count_q + CW'(enq) - CW'(acc);
            err_q     <= err_q || drop;
            burst_q   <= acc;
            trans_q   <= acc && head.sub_id == head.num_req;
            if (acc)
                done_id_q <= head.id;
        end
    end

`ifdef DRAM_REQ_QUEUE_STATS_EN
    logic [31:0] rd_q, wr_q, stall_q;
    assign stat_rd_cnt    = rd_q;
    assign stat_wr_cnt    = wr_q;
    assign stat_stall_cnt = stall_q;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_q    <= '0;
            wr_q    <= '0;
            stall_q <= '0;
        end else begin
            if (acc && !head.write && rd_q != '1)
                rd_q <= rd_q + 32'd1;
            if (acc && head.write && wr_q != '1)
                wr_q <= wr_q + 32'd1;
            if (dram_req_valid && dram_stall && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dram_req_queue_param.sv
// tb_dram_req_queue_param: scoreboard bench for dram_req_queue_param
module tb_dram_req_queue_param;
    logic         CLK = 1'b0, nRST = 1'b0;
    logic         enq_valid = 1'b0, enq_ready, enq_write = 1'b0;
    logic [7:0]   enq_id = '0;
    logic [2:0]   enq_sub_id = '0, enq_num_req = '0;
    logic [31:0]  enq_addr = '0;
    logic [4:0]   enq_num_bytes = 5'd16;
    logic         wdata_valid = 1'b0;
    logic [127:0] wdata = '0;
    logic         dram_stall = 1'b0;
    logic         dram_req_valid, dram_req_write;
    logic [7:0]   dram_req_id;
    logic [31:0]  dram_req_addr;
    logic [4:0]   dram_req_num_bytes;
    logic [127:0] dram_req_wdata;
    logic         burst_complete, transaction_complete;
    logic [7:0]   done_id;
    logic         full, empty, wdata_err;
    logic [3:0]   count;
`ifdef DRAM_REQ_QUEUE_STATS_EN
    logic [31:0]  stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;
`endif

    always #5 CLK = ~CLK;

    dram_req_queue_param dut (
        .CLK(CLK), .nRST(nRST),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_write(enq_write),
        .enq_id(enq_id), .enq_sub_id(enq_sub_id), .enq_num_req(enq_num_req),
        .enq_addr(enq_addr), .enq_num_bytes(enq_num_bytes),
        .wdata_valid(wdata_valid), .wdata(wdata), .dram_stall(dram_stall),
        .dram_req_valid(dram_req_valid), .dram_req_write(dram_req_write),
        .dram_req_id(dram_req_id), .dram_req_addr(dram_req_addr),
        .dram_req_num_bytes(dram_req_num_bytes), .dram_req_wdata(dram_req_wdata),
        .burst_complete(burst_complete), .transaction_complete(transaction_complete),
        .done_id(done_id), .full(full), .empty(empty), .count(count),
        .wdata_err(wdata_err)
`ifdef DRAM_REQ_QUEUE_STATS_EN
        ,
        .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    typedef struct packed {
        logic         w;
        logic [7:0]   id;
        logic [31:0]  addr;
        logic [4:0]   nb;
        logic [127:0] wd;
    } out_t;
    typedef struct packed {
        logic [7:0] id;
        logic       tc;
    } done_t;

    out_t  exp_q[$];
    done_t done_q[$];
    out_t  act_o, exp_o;
    done_t act_d, exp_d;
    int    checks = 0, failures = 0;

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST && dram_req_valid && !dram_stall) begin
            act_o = '{w: dram_req_write, id: dram_req_id, addr: dram_req_addr,
                      nb: dram_req_num_bytes, wd: dram_req_wdata};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL issue: unexpected request id %0h", dram_req_id);
            end else begin
                exp_o = exp_q.pop_front();
                if (act_o !== exp_o) begin
                    failures++;
                    $display("FAIL issue: got %0h expected %0h", act_o, exp_o);
                end
            end
        end
        if (nRST && burst_complete) begin
            act_d = '{id: done_id, tc: transaction_complete};
            checks++;
            if (done_q.size() == 0) begin
                failures++;
                $display("FAIL done: unexpected burst_complete id %0h", done_id);
            end else begin
                exp_d = done_q.pop_front();
                if (act_d !== exp_d) begin
                    failures++;
                    $display("FAIL done: got id/tc %0h expected %0h", act_d, exp_d);
                end
            end
        end else if (nRST && transaction_complete) begin
            checks++;
            failures++;
            $display("FAIL done: transaction_complete without burst_complete");
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic enq(input logic w, input logic [7:0] id, input logic [2:0] sub,
                       input logic [2:0] num, input logic [31:0] addr);
        enq_valid = 1'b1; enq_write = w; enq_id = id; enq_sub_id = sub;
        enq_num_req = num; enq_addr = addr;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic push(input logic w, input logic [7:0] id, input logic [31:0] addr,
                        input logic [127:0] wd, input logic tc);
        exp_q.push_back('{w: w, id: id, addr: addr, nb: 5'd16, wd: wd});
        done_q.push_back('{id: id, tc: tc});
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_q.size() + done_q.size()) != 0; i++)
            tick();
        chk("drain_pending", exp_q.size() + done_q.size(), 0);
    endtask

    localparam logic [127:0] DA = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] D0 = 128'hD0D0_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [127:0] D1 = 128'hD1D1_0000_0000_0000_0000_0000_0000_0002;

    initial begin
        tick();
        tick();
        nRST = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_req_valid", dram_req_valid, 0);
        chk("rst_wdata_err", wdata_err, 0);

        // read transaction id 0x21, three sub-requests back-to-back
        for (int s = 0; s < 3; s++) begin
            push(1'b0, 8'h21, 32'h1000 + 32'(s) * 32'h10, '0, s == 2);
            enq(1'b0, 8'h21, 3'(s), 3'd2, 32'h1000 + 32'(s) * 32'h10);
            if (s == 0)
                chk("rd_latency_valid", dram_req_valid, 1);
        end
        drain();

        // write A blocks read B until its data arrives
        push(1'b1, 8'h30, 32'h3000, DA, 1'b1);
        push(1'b0, 8'h31, 32'h3100, '0, 1'b1);
        enq(1'b1, 8'h30, 3'd0, 3'd0, 32'h3000);
        enq(1'b0, 8'h31, 3'd0, 3'd0, 32'h3100);
        chk("wr_block_valid0", dram_req_valid, 0);
        for (int i = 0; i < 4; i++)
            tick();
        chk("wr_block_valid1", dram_req_valid, 0);
        wdata_valid = 1'b1; wdata = DA;
        tick();
        wdata_valid = 1'b0;
        chk("wr_fill_valid", dram_req_valid, 1);
        chk("wr_fill_data", dram_req_wdata, DA);
        drain();

        // full boundary under stall
        dram_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(1'b0, 8'h40 + 8'(i), 32'h2000 + 32'(i) * 32'h40, '0, i == 7);
            enq(1'b0, 8'h40 + 8'(i), 3'(i), 3'd7, 32'h2000 + 32'(i) * 32'h40);
        end
        chk("full_flag", full, 1);
        chk("full_enq_ready", enq_ready, 0);
        chk("full_count", count, 8);
        enq(1'b0, 8'h4F, 3'd0, 3'd0, 32'h4F00);
        chk("full_drop_count", count, 8);
        push(1'b0, 8'h50, 32'h5000, '0, 1'b1);
        dram_stall = 1'b0;
        enq_valid = 1'b1; enq_write = 1'b0; enq_id = 8'h50; enq_sub_id = 3'd0;
        enq_num_req = 3'd0; enq_addr = 32'h5000;
        tick();
        chk("full_first_acc_count", count, 7);
        chk("full_first_acc_ready", enq_ready, 1);
        tick();
        enq_valid = 1'b0;
        chk("full_enq_acc_count", count, 7);
        drain();
        chk("drained_empty", empty, 1);

        // data ordering and sticky error
        push(1'b1, 8'h60, 32'h6000, D0, 1'b1);
        push(1'b1, 8'h61, 32'h6100, D1, 1'b1);
        enq(1'b1, 8'h60, 3'd0, 3'd0, 32'h6000);
        enq(1'b1, 8'h61, 3'd0, 3'd0, 32'h6100);
        wdata_valid = 1'b1; wdata = D0;
        tick();
        wdata = D1;
        tick();
        wdata_valid = 1'b0;
        drain();
        chk("err_before", wdata_err, 0);
        wdata_valid = 1'b1; wdata = DA;
        tick();
        wdata_valid = 1'b0;
        chk("err_set", wdata_err, 1);
        for (int i = 0; i < 3; i++)
            tick();
        chk("err_sticky", wdata_err, 1);

        // reset mid-operation discards queued entries
        dram_stall = 1'b1;
        for (int i = 0; i < 3; i++)
            enq(1'b0, 8'h80 + 8'(i), 3'd0, 3'd0, 32'h8000);
        chk("pre_rst_count", count, 3);
        #2 nRST = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_req_valid", dram_req_valid, 0);
        chk("midrst_err", wdata_err, 0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        chk("postrst_enq_ready", enq_ready, 1);

        // stall holds the head stable with no pulses
        push(1'b0, 8'h70, 32'h7000, '0, 1'b1);
        enq(1'b0, 8'h70, 3'd0, 3'd0, 32'h7000);
        chk("stall_valid", dram_req_valid, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_addr", dram_req_addr, 32'h7000);
            chk("stall_no_pulse", burst_complete, 0);
        end
`ifdef DRAM_REQ_QUEUE_STATS_EN
        chk("stat_stall_cnt", stat_stall_cnt, 4);
`endif
        dram_stall = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
